// File: rtl/goldschmidt_pkg.sv
// Shared definitions for the sequential Goldschmidt mini-float divider.
// Format: [7] sign, [6:3] exponent (bias 7), [2:0] mantissa with hidden 1.
package goldschmidt_pkg;
  localparam int SIGN    = 7;
  localparam int EXP_HI  = 6;
  localparam int EXP_LO  = 3;
  localparam int MANT_HI = 2;

  localparam logic [3:0] EXP_BIAS = 4'd7;
  localparam logic [7:0] ONE_F    = 8'h38;
  localparam logic [7:0] ZERO_F   = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } gs_state_t;
endpackage

// File: rtl/goldschmidt_seed_rom.sv
// Reciprocal exponent seed: maps a divisor exponent e to 14 - e, so that
// divisor * seed lands in [1, 2) before the first iteration. e == 15 has no
// representable reciprocal and clamps to 0.
// Ports:
//   i_exp      divisor exponent field
//   o_seed_exp seed exponent for the initial factor xi
module goldschmidt_seed_rom (
  input  logic [3:0] i_exp,
  output logic [3:0] o_seed_exp
);
  always_comb begin
    o_seed_exp = 4'd0;
    if (i_exp != 4'b1111) o_seed_exp = 4'd14 - i_exp;
  end
endmodule

// File: rtl/goldschmidt_seq_ctrl.sv
// Sequential Goldschmidt division controller. Drives one external
// combinational stage (div_a/div_b/div_xi -> div_c/div_d/div_xinew) once per
// cycle until convergence or the iteration cap, with zero fast paths.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, a_in, b_in request and mini-float operands (taken in IDLE only)
//   busy, done        operation in flight / one-cycle completion pulse
//   q_out             quotient, held until the next accepted start
//   err_div0          divisor was zero
//   not_conv          cap reached without convergence
//   iter_count        iterations performed
//   div_a/b/xi        registered stage inputs
//   div_c/d/xinew     stage outputs
module goldschmidt_seq_ctrl
  import goldschmidt_pkg::*;
#(
  parameter int unsigned     MAX_ITER = 3,
  parameter logic [2:0]      TOL_MANT = 3'b100,
  parameter int unsigned     ITER_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        a_in,
  input  logic [7:0]        b_in,
  output logic              busy,
  output logic              done,
  output logic [7:0]        q_out,
  output logic              err_div0,
  output logic              not_conv,
  output logic [ITER_W-1:0] iter_count,
  output logic [7:0]        div_a,
  output logic [7:0]        div_b,
  output logic [7:0]        div_xi,
  input  logic [7:0]        div_c,
  input  logic [7:0]        div_d,
  input  logic [7:0]        div_xinew
);
  localparam logic [ITER_W:0] MAX_ITER_C = MAX_ITER[ITER_W:0];

  gs_state_t         r_state;
  logic [7:0]        r_a, r_b, r_xi, r_q;
  logic              r_busy, r_done, r_div0, r_nc;
  logic [ITER_W-1:0] r_iter;

  logic [3:0]        w_seed_exp;
  logic              w_conv, w_cap;
  logic [ITER_W-1:0] w_iter_nxt;

  goldschmidt_seed_rom u_seed (
    .i_exp      (r_b[EXP_HI:EXP_LO]),
    .o_seed_exp (w_seed_exp)
  );

  // Converged when C reached 1.0, or sits just below 1.0 (exponent 6) with a
  // mantissa at or above the tolerance; a collapsed factor also stops the loop.
  assign w_conv = (div_c == ONE_F) ||
                  (!div_c[SIGN] && (div_c[EXP_HI:EXP_LO] == 4'b0110) &&
                   (div_c[MANT_HI:0] >= TOL_MANT)) ||
                  (div_xinew == ZERO_F);
  assign w_iter_nxt = r_iter + 1'b1;
  // Widened by one bit so that the cap compare cannot wrap.
  assign w_cap = (({1'b0, r_iter} + 1'b1) == MAX_ITER_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= ZERO_F;
      r_b     <= ZERO_F;
      r_xi    <= ZERO_F;
      r_q     <= ZERO_F;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_nc    <= 1'b0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a    <= a_in;
            r_b    <= b_in;
            r_q    <= ZERO_F;
            r_div0 <= 1'b0;
            r_nc   <= 1'b0;
            r_iter <= '0;
            r_busy <= 1'b1;
            if (b_in[EXP_HI:0] == 7'd0) begin
              r_div0  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (a_in[EXP_HI:0] == 7'd0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= SEED;
            end
          end
        end
        SEED: begin
          r_xi    <= {1'b0, w_seed_exp, 3'b000};
          r_state <= ITER;
        end
        ITER: begin
          r_xi   <= div_xinew;
          r_q    <= div_d;
          r_iter <= w_iter_nxt;
          if (w_conv) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_cap) begin
            r_nc    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign q_out      = r_q;
  assign err_div0   = r_div0;
  assign not_conv   = r_nc;
  assign iter_count = r_iter;
  assign div_a      = r_a;
  assign div_b      = r_b;
  assign div_xi     = r_xi;
endmodule
